// File: rtl/track_mode_ctrl_pkg.sv
// Shared motion-mode and route-command encodings for the line-follower controller
// and the motor driver that consumes its mode output.
package track_mode_ctrl_pkg;

  typedef logic [4:0] mode_t;
  typedef logic [2:0] turn_t;

  localparam int unsigned SENSOR_W = 3;
  localparam int unsigned TIMER_W  = 28;

  localparam logic [4:0] MODE_IDLE         = 5'd0;
  localparam logic [4:0] MODE_START        = 5'd1;
  localparam logic [4:0] MODE_COUNT        = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT     = 5'd3;
  localparam logic [4:0] MODE_CHOOSE       = 5'd4;
  localparam logic [4:0] MODE_LEFT         = 5'd5;
  localparam logic [4:0] MODE_RIGHT        = 5'd6;
  localparam logic [4:0] MODE_BACK         = 5'd7;
  localparam logic [4:0] MODE_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] MODE_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] MODE_STOP         = 5'd30;
  localparam logic [4:0] MODE_ERROR        = 5'd31;

  localparam logic [2:0] TURN_STRAIGHT = 3'd0;
  localparam logic [2:0] TURN_LEFT     = 3'd1;
  localparam logic [2:0] TURN_RIGHT    = 3'd2;
  localparam logic [2:0] TURN_BACK     = 3'd3;
  localparam logic [2:0] TURN_STOP     = 3'd4;

  function automatic logic is_tracking(input mode_t m);
    return (m == MODE_STRAIGHT) || (m == MODE_LITTLE_LEFT) || (m == MODE_LITTLE_RIGHT);
  endfunction

endpackage

// File: rtl/track_sensor_filter.sv
// Two-flop synchronizer plus debounce for the {L,M,R} IR line sensors; the
// filtered vector only moves after DEBOUNCE identical synced samples.
module track_sensor_filter
  import track_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SENSOR_W-1:0] sensor_i,
  output logic [SENSOR_W-1:0] filt_o
);

  localparam logic [7:0] DB_N = 8'(DEBOUNCE);

  logic [SENSOR_W-1:0] sync1_q, sync2_q, cand_q, filt_q, filt_d;
  logic [7:0]          cnt_q, cnt_d, nsamp;

  // A sample different from the previous one restarts the run at length one.
  always_comb begin
    nsamp  = (sync2_q == cand_q) ? cnt_q + 8'd1 : 8'd1;
    filt_d = filt_q;
    cnt_d  = 8'd0;
    if (sync2_q != filt_q) begin
      if (nsamp >= DB_N) filt_d = sync2_q;
      else               cnt_d  = nsamp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/track_mode_ctrl.sv
// Line-follower decision FSM driving the motor mode; state | meaning:
// IDLE/STOP wait start | START,COUNT countdown | STRAIGHT,LITTLE_* track | CHOOSE at cross | LEFT,RIGHT,BACK turn | ERROR sticky
module track_mode_ctrl
  import track_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned START_DELAY = 100_000_000,
  parameter int unsigned TURN_MIN    = 20_000_000,
  parameter int unsigned BACK_MIN    = 40_000_000,
  parameter int unsigned TURN_MAX    = 200_000_000,
  parameter int unsigned LOST_MAX    = 50_000_000,
  parameter int unsigned CHOOSE_MAX  = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] sensor_i,
  input  logic       route_valid_i,
  input  logic [2:0] next_turn_i,
  output logic       turn_ack_o,
  output logic [4:0] mode_o,
  output logic [4:0] lastMode_o,
  output logic [7:0] cross_cnt_o
);

  localparam logic [TIMER_W-1:0] COUNT_END  = TIMER_W'(START_DELAY - 1);
  localparam logic [TIMER_W-1:0] TURN_MIN_T = TIMER_W'(TURN_MIN);
  localparam logic [TIMER_W-1:0] BACK_MIN_T = TIMER_W'(BACK_MIN);
  localparam logic [TIMER_W-1:0] TURN_END   = TIMER_W'(TURN_MAX - 1);
  localparam logic [TIMER_W-1:0] LOST_END   = TIMER_W'(LOST_MAX - 1);
  localparam logic [TIMER_W-1:0] CHOOSE_END = TIMER_W'(CHOOSE_MAX - 1);

  logic [2:0]         filt;
  logic [4:0]         mode_q, mode_d, last_q, last_d;
  logic [TIMER_W-1:0] timer_q, timer_d, lost_q, lost_d, turn_min;
  logic [7:0]         cross_q, cross_d;
  logic               ack_q, ack_d;

  track_sensor_filter #(
    .DEBOUNCE(DEBOUNCE)
  ) u_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sensor_i(sensor_i),
    .filt_o  (filt)
  );

  assign turn_min = (mode_q == MODE_BACK) ? BACK_MIN_T : TURN_MIN_T;

  always_comb begin
    mode_d  = mode_q;
    lost_d  = '0;
    ack_d   = 1'b0;
    cross_d = cross_q;
    case (mode_q)
      MODE_IDLE, MODE_STOP: if (start_i) mode_d = MODE_START;
      MODE_START:           mode_d = MODE_COUNT;
      MODE_COUNT:           if (timer_q == COUNT_END) mode_d = MODE_STRAIGHT;
      MODE_STRAIGHT, MODE_LITTLE_LEFT, MODE_LITTLE_RIGHT: begin
        case (filt)
          3'b010:         mode_d = MODE_STRAIGHT;
          3'b110, 3'b100: mode_d = MODE_LITTLE_LEFT;
          3'b011, 3'b001: mode_d = MODE_LITTLE_RIGHT;
          3'b111:         mode_d = MODE_CHOOSE;
          3'b000: begin
            if (lost_q == LOST_END) mode_d = MODE_ERROR;
            else                    lost_d = lost_q + 1'b1;
          end
          default: ;
        endcase
      end
      MODE_CHOOSE: begin
        if (filt == 3'b111) begin
          if (timer_q == CHOOSE_END) mode_d = MODE_ERROR;
        end else if (route_valid_i) begin
          // Illegal commands are still consumed so the route source advances.
          ack_d   = 1'b1;
          cross_d = (cross_q == 8'hFF) ? cross_q : cross_q + 8'd1;
          case (next_turn_i)
            TURN_STRAIGHT: mode_d = MODE_STRAIGHT;
            TURN_LEFT:     mode_d = MODE_LEFT;
            TURN_RIGHT:    mode_d = MODE_RIGHT;
            TURN_BACK:     mode_d = MODE_BACK;
            TURN_STOP:     mode_d = MODE_STOP;
            default:       mode_d = MODE_ERROR;
          endcase
        end else begin
          mode_d = MODE_STOP;
        end
      end
      MODE_LEFT, MODE_RIGHT, MODE_BACK: begin
        if ((timer_q >= turn_min) && (filt == 3'b010)) mode_d = MODE_STRAIGHT;
        else if (timer_q == TURN_END)                  mode_d = MODE_ERROR;
      end
      MODE_ERROR: ;
      default:    mode_d = MODE_ERROR;
    endcase
  end

  always_comb begin
    if (mode_d != mode_q) begin
      timer_d = '0;
      last_d  = mode_q;
    end else begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
      last_d  = last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_IDLE;
      last_q  <= MODE_IDLE;
      timer_q <= '0;
      lost_q  <= '0;
      cross_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      lost_q  <= lost_d;
      cross_q <= cross_d;
      ack_q   <= ack_d;
    end
  end

  assign turn_ack_o  = ack_q;
  assign mode_o      = mode_q;
  assign lastMode_o  = last_q;
  assign cross_cnt_o = cross_q;

endmodule

// File: tb/tb_track_mode_ctrl.sv
// Directed bench for track_mode_ctrl with small timing parameters; every
// expected value below is hand-derived from the mode/latency rules.
module tb_track_mode_ctrl;

  localparam logic [4:0] M_IDLE = 5'd0, M_START = 5'd1, M_COUNT = 5'd2, M_STRAIGHT = 5'd3;
  localparam logic [4:0] M_CHOOSE = 5'd4, M_LEFT = 5'd5, M_RIGHT = 5'd6, M_BACK = 5'd7;
  localparam logic [4:0] M_LL = 5'd8, M_LR = 5'd9, M_STOP = 5'd30, M_ERROR = 5'd31;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       route_valid = 1'b0;
  logic [2:0] sensor = 3'b010;
  logic [2:0] next_turn = 3'd0;
  logic       turn_ack;
  logic [4:0] mode, last_mode;
  logic [7:0] cross_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  track_mode_ctrl #(
    .DEBOUNCE   (2),
    .START_DELAY(10),
    .TURN_MIN   (5),
    .BACK_MIN   (8),
    .TURN_MAX   (40),
    .LOST_MAX   (12),
    .CHOOSE_MAX (20)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .sensor_i     (sensor),
    .route_valid_i(route_valid),
    .next_turn_i  (next_turn),
    .turn_ack_o   (turn_ack),
    .mode_o       (mode),
    .lastMode_o   (last_mode),
    .cross_cnt_o  (cross_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic restart();
    start = 1'b1;
    step(1);
    check_eq("restart_start", 32'(mode), 32'(M_START));
    start = 1'b0;
    step(11);
    check_eq("restart_straight", 32'(mode), 32'(M_STRAIGHT));
  endtask

  task automatic enter_choose();
    sensor = 3'b111;
    step(5);
    check_eq("enter_choose", 32'(mode), 32'(M_CHOOSE));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sensor = 3'b010;
    step(1);
    check_eq("rst_mode", 32'(mode), 32'(M_IDLE));
    check_eq("rst_last", 32'(last_mode), 32'(M_IDLE));
    check_eq("rst_cross", 32'(cross_cnt), 32'd0);
    check_eq("rst_ack", 32'(turn_ack), 32'd0);
    rst = 1'b0;
    step(6);
  endtask

  initial begin
    // Reset and countdown
    step(2);
    do_reset();
    check_eq("idle_hold", 32'(mode), 32'(M_IDLE));
    start = 1'b1;
    step(1);
    check_eq("t1_start", 32'(mode), 32'(M_START));
    check_eq("t1_start_last", 32'(last_mode), 32'(M_IDLE));
    start = 1'b0;
    step(1);
    check_eq("t1_count_first", 32'(mode), 32'(M_COUNT));
    step(9);
    check_eq("t1_count_last", 32'(mode), 32'(M_COUNT));
    step(1);
    check_eq("t1_straight", 32'(mode), 32'(M_STRAIGHT));
    check_eq("t1_last_count", 32'(last_mode), 32'(M_COUNT));
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("start_ignored", 32'(mode), 32'(M_STRAIGHT));

    // Drift correction
    sensor = 3'b110;
    step(4);
    check_eq("t2_ll_not_yet", 32'(mode), 32'(M_STRAIGHT));
    step(1);
    check_eq("t2_ll", 32'(mode), 32'(M_LL));
    check_eq("t2_ll_last", 32'(last_mode), 32'(M_STRAIGHT));
    sensor = 3'b010;
    step(5);
    check_eq("t2_back_straight", 32'(mode), 32'(M_STRAIGHT));
    check_eq("t2_last_ll", 32'(last_mode), 32'(M_LL));
    sensor = 3'b011;
    step(5);
    check_eq("t2_lr", 32'(mode), 32'(M_LR));
    sensor = 3'b101;
    step(5);
    check_eq("t2_hold_101", 32'(mode), 32'(M_LR));
    sensor = 3'b010;
    step(5);
    check_eq("t2_straight2", 32'(mode), 32'(M_STRAIGHT));

    // Intersection left turn
    route_valid = 1'b1;
    next_turn   = 3'd1;
    enter_choose();
    sensor = 3'b010;
    step(4);
    check_eq("t3_choose_hold", 32'(mode), 32'(M_CHOOSE));
    check_eq("t3_no_ack_yet", 32'(turn_ack), 32'd0);
    step(1);
    check_eq("t3_left", 32'(mode), 32'(M_LEFT));
    check_eq("t3_ack", 32'(turn_ack), 32'd1);
    check_eq("t3_cross", 32'(cross_cnt), 32'd1);
    check_eq("t3_last_choose", 32'(last_mode), 32'(M_CHOOSE));
    route_valid = 1'b0;
    step(1);
    check_eq("t3_ack_single", 32'(turn_ack), 32'd0);
    step(4);
    check_eq("t3_left_min", 32'(mode), 32'(M_LEFT));
    step(1);
    check_eq("t3_exit", 32'(mode), 32'(M_STRAIGHT));
    check_eq("t3_last_left", 32'(last_mode), 32'(M_LEFT));

    // Back turn uses the longer minimum
    route_valid = 1'b1;
    next_turn   = 3'd3;
    enter_choose();
    sensor = 3'b010;
    step(5);
    check_eq("t3b_back", 32'(mode), 32'(M_BACK));
    check_eq("t3b_cross", 32'(cross_cnt), 32'd2);
    route_valid = 1'b0;
    step(8);
    check_eq("t3b_back_min", 32'(mode), 32'(M_BACK));
    step(1);
    check_eq("t3b_exit", 32'(mode), 32'(M_STRAIGHT));

    // Right turn: exit arrives on the timeout cycle and must win
    route_valid = 1'b1;
    next_turn   = 3'd2;
    enter_choose();
    sensor = 3'b000;
    step(5);
    check_eq("t6a_right", 32'(mode), 32'(M_RIGHT));
    check_eq("t6a_cross", 32'(cross_cnt), 32'd3);
    route_valid = 1'b0;
    step(35);
    sensor = 3'b010;
    step(4);
    check_eq("t6a_right_39", 32'(mode), 32'(M_RIGHT));
    step(1);
    check_eq("t6a_exit_wins", 32'(mode), 32'(M_STRAIGHT));

    // Missing route
    enter_choose();
    sensor = 3'b010;
    step(4);
    check_eq("t4_choose", 32'(mode), 32'(M_CHOOSE));
    step(1);
    check_eq("t4_stop", 32'(mode), 32'(M_STOP));
    check_eq("t4_no_ack", 32'(turn_ack), 32'd0);
    check_eq("t4_cross_kept", 32'(cross_cnt), 32'd3);
    restart();
    check_eq("t4_cross_after_restart", 32'(cross_cnt), 32'd3);

    // Line lost, with one interrupted run that must clear the counter
    sensor = 3'b000;
    step(10);
    sensor = 3'b010;
    step(5);
    check_eq("t5_lost_cleared", 32'(mode), 32'(M_STRAIGHT));
    sensor = 3'b000;
    step(15);
    check_eq("t5_lost_11", 32'(mode), 32'(M_STRAIGHT));
    step(1);
    check_eq("t5_error", 32'(mode), 32'(M_ERROR));
    check_eq("t5_last", 32'(last_mode), 32'(M_STRAIGHT));
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("t5_error_sticky", 32'(mode), 32'(M_ERROR));
    do_reset();
    restart();

    // Turn timeout
    route_valid = 1'b1;
    next_turn   = 3'd1;
    enter_choose();
    sensor = 3'b000;
    step(5);
    check_eq("t6b_left", 32'(mode), 32'(M_LEFT));
    check_eq("t6b_cross", 32'(cross_cnt), 32'd1);
    route_valid = 1'b0;
    step(39);
    check_eq("t6b_left_39", 32'(mode), 32'(M_LEFT));
    step(1);
    check_eq("t6b_timeout", 32'(mode), 32'(M_ERROR));
    check_eq("t6b_last", 32'(last_mode), 32'(M_LEFT));
    do_reset();
    restart();

    // Illegal route command
    route_valid = 1'b1;
    next_turn   = 3'd6;
    enter_choose();
    sensor = 3'b010;
    step(5);
    check_eq("t7_error", 32'(mode), 32'(M_ERROR));
    check_eq("t7_ack", 32'(turn_ack), 32'd1);
    check_eq("t7_cross", 32'(cross_cnt), 32'd1);
    route_valid = 1'b0;
    step(1);
    check_eq("t7_ack_single", 32'(turn_ack), 32'd0);
    check_eq("t7_error_hold", 32'(mode), 32'(M_ERROR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/track_mode_ctrl.md
Name: track_mode_ctrl

Overview:
- Decision FSM that produces the 5-bit motion mode consumed by the motor driver. It is the initiator side of the mode/lastMode interface.
- Reads three IR line sensors, runs start countdown, line tracking, intersection handling and turns, and reports faults.
- At each intersection it takes the next manoeuvre from an upstream route source via a valid/ack handshake.
- Sits between the sensor pins / route ROM and the motor block.

Parameters:
- DEBOUNCE, 4: consecutive stable synced samples required before filtered sensors update (1..255).
- START_DELAY, 100_000_000: cycles spent in COUNT before moving.
- TURN_MIN, 20_000_000: minimum cycles in LEFT/RIGHT before the exit condition is checked.
- BACK_MIN, 40_000_000: minimum cycles in BACK before the exit condition is checked.
- TURN_MAX, 200_000_000: cycles in LEFT/RIGHT/BACK without exit, then ERROR.
- LOST_MAX, 50_000_000: consecutive cycles of filtered 000 while tracking, then ERROR.
- CHOOSE_MAX, 50_000_000: cycles in CHOOSE with sensors still 111, then ERROR.

Ports:
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: start request, one-cycle pulse.
- sensor, input, 3: raw IR {L,M,R}, 1 = line seen; asynchronous.
- route_valid, input, 1: next_turn holds a valid command.
- next_turn, input, 3: 0 straight, 1 left, 2 right, 3 back, 4 stop, 5-7 illegal.
- turn_ack, output, 1: one-cycle pulse; route command consumed.
- mode, output, 5: current motion mode (registered).
- lastMode, output, 5: previous distinct mode.
- cross_cnt, output, 8: intersections passed, saturating.

Behaviour:
- Mode codes: IDLE 0, START 1, COUNT 2, STRAIGHT 3, CHOOSE 4, LEFT 5, RIGHT 6, BACK 7, LITTLE_LEFT 8, LITTLE_RIGHT 9, STOP 30, ERROR 31. No other values are ever driven.
- Reset (synchronous) values: mode=IDLE, lastMode=IDLE, turn_ack=0, cross_cnt=0, filtered sensors=000, timer=0, lost counter=0, debounce counter=0.
- Sensor path: 2-flop synchronizer, then debounce. The filtered value changes DEBOUNCE+2 cycles after a stable raw change. Mode reacts 1 cycle later, so total latency is DEBOUNCE+3.
- Single 28-bit timer: cleared on every mode change, otherwise increments, saturating.
- lastMode: in any cycle where the next mode differs from mode, lastMode <= mode. Otherwise it holds.

State transitions:
- IDLE: start -> START.
- START: one cycle -> COUNT.
- COUNT: timer == START_DELAY-1 -> STRAIGHT.
- Tracking states (STRAIGHT, LITTLE_LEFT, LITTLE_RIGHT), on filtered f:
  - 010 -> STRAIGHT.
  - 110 or 100 -> LITTLE_LEFT.
  - 011 or 001 -> LITTLE_RIGHT.
  - 111 -> CHOOSE.
  - 101 -> hold current mode.
  - 000 -> hold current mode and increment the lost counter; lost counter == LOST_MAX-1 -> ERROR.
  - The lost counter clears on any f != 000.
- CHOOSE, while f == 111: stay; timer == CHOOSE_MAX-1 -> ERROR.
- CHOOSE, on the first cycle with f != 111:
  - If route_valid: pulse turn_ack that cycle, cross_cnt += 1 (sticks at 255), then go to STRAIGHT/LEFT/RIGHT/BACK/STOP per next_turn. Codes 5-7 -> ERROR; turn_ack still pulses and cross_cnt still increments.
  - If !route_valid: go to STOP, with no ack and no increment.
- LEFT / RIGHT: after timer >= TURN_MIN, f == 010 -> STRAIGHT. Timer == TURN_MAX-1 -> ERROR.
- BACK: same as LEFT/RIGHT with BACK_MIN in place of TURN_MIN.
- STOP: start -> START; cross_cnt is kept.
- ERROR: sticky. Only rst leaves it; start is ignored.

Boundary cases:
- start in any state other than IDLE/STOP: ignored.
- Exit and timeout in the same cycle: the exit wins.
- rst mid-turn: all state returns to reset values on the next edge.
- turn_ack is never asserted for more than one consecutive cycle.

Decomposition:
- Shared package holds the mode code constants (mode encoding) and the next_turn encoding. The motor driver uses the same constants.
- One sub-module, track_sensor_filter: 2-flop synchronizer plus the DEBOUNCE-counter filter, producing the 3-bit filtered vector.

Test Plan (bench parameters: DEBOUNCE=2, START_DELAY=10, TURN_MIN=5, BACK_MIN=8, TURN_MAX=40, LOST_MAX=12, CHOOSE_MAX=20):
- Start countdown: rst, then start pulse -> mode START for 1 cycle, COUNT for 10 cycles, then STRAIGHT; lastMode = COUNT.
- Drift correction: in STRAIGHT, sensor=110 held -> LITTLE_LEFT exactly 5 cycles later; sensor=010 -> STRAIGHT, lastMode = LITTLE_LEFT.
- Intersection left turn: sensor=111 then 010, with route_valid=1 and next_turn=1 -> CHOOSE, then turn_ack for 1 cycle, cross_cnt=1, LEFT. Holding 010 exits to STRAIGHT only once timer >= 5.
- Missing route: route_valid=0 at CHOOSE exit -> STOP, no turn_ack, cross_cnt unchanged. A start pulse then gives START.
- Line lost: sensor=000 while tracking -> ERROR after 12 cycles of filtered 000. A start pulse keeps ERROR; rst returns IDLE with cross_cnt=0.
- Turn timeout: LEFT with sensor stuck at 000 -> ERROR at timer 39. Illegal next_turn=6 -> ERROR with a single turn_ack pulse.
